// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Sequential unsigned multiply/divide unit (one bit per cycle)
//               with a single register-file write-back per operation.
//               Optional macro MDU_REM_SEL_EN adds rem_sel (remainder select).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic [W-1:0]  src_a,
    input  logic [W-1:0]  src_b,
    input  logic [AW-1:0] dst_addr,
`ifdef MDU_REM_SEL_EN
    input  logic          rem_sel,
`endif
    output logic          busy,
    output logic          done,
    output logic          div_zero,
    output logic          L_S,
    output logic [AW-1:0] Wt_addr,
    output logic [W-1:0]  Wt_data
);

    localparam int          CW     = $clog2(W) + 1;
    localparam logic [CW-1:0] c_last = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_op;
    logic          r_dz;
    logic [AW-1:0] r_dst;
    // r_a: multiplicand (mul) or dividend shifting into quotient (div)
    // r_b: multiplier (mul) or divisor (div)
    // r_acc: product accumulator (mul) or partial remainder (div)
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
`ifdef MDU_REM_SEL_EN
    logic          r_rem_sel;
`endif

    logic          w_accept;
    logic          w_dz_in;
    logic [W-1:0]  w_sum;
    logic [W:0]    w_shift;
    logic          w_ge;
    logic [W-1:0]  w_sub;
    logic [W-1:0]  w_result;

    // Outputs lag state by one cycle, so busy is checked to avoid
    // accepting a request during the trailing write-back cycle.
    assign w_accept = (r_state == S_IDLE) && start && !busy;
    assign w_dz_in  = op && (src_b == '0);

    assign w_sum   = r_acc + r_a;
    assign w_shift = {r_acc, r_a[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_sub   = W'(w_shift - {1'b0, r_b});

    always_comb begin
        w_result = r_acc;
        if (r_op) begin
`ifdef MDU_REM_SEL_EN
            if (r_rem_sel) begin
                w_result = r_dz ? r_a : r_acc;
            end else begin
                w_result = r_dz ? {W{1'b1}} : r_a;
            end
`else
            w_result = r_dz ? {W{1'b1}} : r_a;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_dz_in ? S_WB : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_op      <= 1'b0;
            r_dz      <= 1'b0;
            r_dst     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
`ifdef MDU_REM_SEL_EN
            r_rem_sel <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_op      <= op;
            r_dz      <= w_dz_in;
            r_dst     <= dst_addr;
            r_a       <= src_a;
            r_b       <= src_b;
            r_acc     <= '0;
`ifdef MDU_REM_SEL_EN
            r_rem_sel <= rem_sel;
`endif
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_op) begin
                if (r_b[0]) begin
                    r_acc <= w_sum;
                end
                r_a <= {r_a[W-2:0], 1'b0};
                r_b <= {1'b0, r_b[W-1:1]};
            end else begin
                r_acc <= w_ge ? w_sub : w_shift[W-1:0];
                r_a   <= {r_a[W-2:0], w_ge};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            L_S      <= 1'b0;
            Wt_addr  <= '0;
            Wt_data  <= '0;
        end else begin
            busy     <= (r_state != S_IDLE);
            done     <= (r_state == S_WB);
            div_zero <= (r_state == S_WB) && r_dz;
            // r0 is hard-wired zero: never write it
            L_S      <= (r_state == S_WB) && (r_dst != '0);
            if (r_state == S_WB) begin
                Wt_addr <= r_dst;
                Wt_data <= w_result;
            end
        end
    end

endmodule
`default_nettype wire
